// File: rtl/uart_io_ctrl.sv
// rtl/uart_io_ctrl.sv - UART byte bridge: exec writes serialised MSB-first to tx, rx bytes assembled into reads
// Define UART_IO_WQUEUE_EN for the WQ_DEPTH-entry write queue; otherwise a single entry is held until sent.
module uart_io_ctrl #(
  parameter int WQ_DEPTH  = 4,
  parameter int RXQ_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  input  logic [1:0]  uart_rsz,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_overflow
);

  function automatic logic [1:0] last_idx(input logic [1:0] sz);
    case (sz)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  logic        head_valid;
  logic [31:0] head_data;
  logic [1:0]  head_last;
  logic [1:0]  tx_bcnt;
  logic [1:0]  byte_sel;
  logic        tx_fire;
  logic        tx_pop;

  assign tx_fire  = head_valid && tx_ready;
  assign tx_pop   = tx_fire && (tx_bcnt == head_last);
  assign byte_sel = head_last - tx_bcnt;
  assign tx_valid = head_valid;

  always_comb begin
    tx_data = 8'h00;
    if (head_valid) begin
      case (byte_sel)
        2'd0:    tx_data = head_data[7:0];
        2'd1:    tx_data = head_data[15:8];
        2'd2:    tx_data = head_data[23:16];
        default: tx_data = head_data[31:24];
      endcase
    end
  end

`ifdef UART_IO_WQUEUE_EN
  localparam int WQ_AW = $clog2(WQ_DEPTH);
  localparam logic [WQ_AW:0] WQ_FULL = (WQ_AW+1)'(WQ_DEPTH);

  logic [31:0]      wq_data [WQ_DEPTH];
  logic [1:0]       wq_last [WQ_DEPTH];
  logic [WQ_AW-1:0] wq_wptr;
  logic [WQ_AW-1:0] wq_rptr;
  logic [WQ_AW:0]   wq_count;
  logic             wq_full;
  logic             wq_push;
  logic [31:0]      push_data;
  logic [1:0]       push_last;
  logic             pend_valid;
  logic [31:0]      pend_data;
  logic [1:0]       pend_last;

  assign head_valid = (wq_count != '0);
  assign head_data  = wq_data[wq_rptr];
  assign head_last  = wq_last[wq_rptr];
  assign wq_full    = (wq_count == WQ_FULL);

  // A parked request has priority; new requests are not issued while one is parked.
  always_comb begin
    wq_push   = 1'b0;
    push_data = uart_wd;
    push_last = last_idx(uart_wsz);
    if (pend_valid) begin
      wq_push   = !wq_full;
      push_data = pend_data;
      push_last = pend_last;
    end else begin
      wq_push = uart_wenable && !wq_full;
    end
  end

  always_ff @(posedge clk) begin
    if (wq_push) begin
      wq_data[wq_wptr] <= push_data;
      wq_last[wq_wptr] <= push_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wq_wptr    <= '0;
      wq_rptr    <= '0;
      wq_count   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_last  <= '0;
      tx_bcnt    <= '0;
      uart_wdone <= 1'b0;
    end else begin
      uart_wdone <= wq_push;
      if (wq_push) wq_wptr <= wq_wptr + 1'b1;
      if (tx_fire) begin
        if (tx_pop) begin
          tx_bcnt <= '0;
          wq_rptr <= wq_rptr + 1'b1;
        end else begin
          tx_bcnt <= tx_bcnt + 2'd1;
        end
      end
      wq_count <= wq_count + (WQ_AW+1)'(wq_push) - (WQ_AW+1)'(tx_pop);
      if (!pend_valid && uart_wenable && wq_full) begin
        pend_valid <= 1'b1;
        pend_data  <= uart_wd;
        pend_last  <= last_idx(uart_wsz);
      end else if (pend_valid && wq_push) begin
        pend_valid <= 1'b0;
      end
    end
  end
`else
  logic        ent_valid;
  logic [31:0] ent_data;
  logic [1:0]  ent_last;
  logic        ent_load;

  assign head_valid = ent_valid;
  assign head_data  = ent_data;
  assign head_last  = ent_last;
  // Queue depth has no meaning here; the term is constant true.
  assign ent_load   = uart_wenable && !ent_valid && (WQ_DEPTH > 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid  <= 1'b0;
      ent_data   <= '0;
      ent_last   <= '0;
      tx_bcnt    <= '0;
      uart_wdone <= 1'b0;
    end else begin
      uart_wdone <= tx_pop;
      if (tx_fire) tx_bcnt <= tx_pop ? 2'd0 : tx_bcnt + 2'd1;
      if (ent_load) begin
        ent_valid <= 1'b1;
        ent_data  <= uart_wd;
        ent_last  <= last_idx(uart_wsz);
      end else if (tx_pop) begin
        ent_valid <= 1'b0;
      end
    end
  end
`endif

  localparam int RX_AW = $clog2(RXQ_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RXQ_DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_COLLECT, RD_DONE} rd_state_t;

  rd_state_t        rd_state;
  logic [1:0]       rd_cnt;
  logic [1:0]       rd_last;
  logic [23:0]      rd_acc;
  logic [7:0]       rxq_mem [RXQ_DEPTH];
  logic [RX_AW-1:0] rxq_wptr;
  logic [RX_AW-1:0] rxq_rptr;
  logic [RX_AW:0]   rxq_count;
  logic             rxq_full;
  logic             rxq_empty;
  logic             rxq_push;
  logic             rxq_pop;
  logic [7:0]       rxq_head;

  assign rxq_full  = (rxq_count == RX_FULL);
  assign rxq_empty = (rxq_count == '0);
  assign rxq_head  = rxq_mem[rxq_rptr];
  assign rxq_pop   = (rd_state == RD_COLLECT) && !rxq_empty;
  assign rxq_push  = rx_valid && (!rxq_full || rxq_pop);

  always_ff @(posedge clk) begin
    if (rxq_push) rxq_mem[rxq_wptr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxq_wptr    <= '0;
      rxq_rptr    <= '0;
      rxq_count   <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rxq_push) rxq_wptr <= rxq_wptr + 1'b1;
      if (rxq_pop)  rxq_rptr <= rxq_rptr + 1'b1;
      rxq_count <= rxq_count + (RX_AW+1)'(rxq_push) - (RX_AW+1)'(rxq_pop);
      if (rx_valid && !rxq_push) rx_overflow <= 1'b1;
    end
  end

  // Bytes shift in from the low end so the first byte read ends up most significant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= RD_IDLE;
      rd_cnt     <= '0;
      rd_last    <= '0;
      rd_acc     <= '0;
      uart_rd    <= '0;
      uart_rdone <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          uart_rdone <= 1'b0;
          if (uart_renable) begin
            rd_last  <= last_idx(uart_rsz);
            rd_cnt   <= '0;
            rd_acc   <= '0;
            rd_state <= RD_COLLECT;
          end
        end
        RD_COLLECT: begin
          if (rxq_pop) begin
            rd_acc <= {rd_acc[15:0], rxq_head};
            rd_cnt <= rd_cnt + 2'd1;
            if (rd_cnt == rd_last) begin
              uart_rd    <= {rd_acc, rxq_head};
              uart_rdone <= 1'b1;
              rd_state   <= RD_DONE;
            end
          end
        end
        RD_DONE: begin
          uart_rdone <= 1'b0;
          rd_state   <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_io_ctrl.md
UART_IO_CTRL -- requirements
Module: uart_io_ctrl

Interface
REQ-001 SHALL have parameter WQ_DEPTH, default 4, meaning the write-command queue depth in entries (power of 2, at least 2).
REQ-002 SHALL have parameter RXQ_DEPTH, default 16, meaning the receive byte FIFO depth (power of 2, at least 4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port uart_wenable, input, 1 bit: one-cycle write request pulse from exec.
REQ-006 SHALL have port uart_wsz, input, 2 bits: write size; 00 = 1 byte, 01 = 2 bytes, 10 or 11 = 4 bytes.
REQ-007 SHALL have port uart_wd, input, 32 bits: write data, sampled with uart_wenable.
REQ-008 SHALL have port uart_wdone, output, 1 bit: one-cycle write acknowledge to exec.
REQ-009 SHALL have port uart_renable, input, 1 bit: one-cycle read request pulse.
REQ-010 SHALL have port uart_rsz, input, 2 bits: read size, same encoding as uart_wsz.
REQ-011 SHALL have port uart_rd, output, 32 bits: assembled read data.
REQ-012 SHALL have port uart_rdone, output, 1 bit: one-cycle read-complete pulse.
REQ-013 SHALL have port tx_data, output, 8 bits: byte presented to the UART transmitter.
REQ-014 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-015 SHALL have port tx_ready, input, 1 bit: transmitter accepts a byte; a transfer occurs in any cycle where tx_valid and tx_ready are both high.
REQ-016 SHALL have port rx_data, input, 8 bits: byte from the UART receiver.
REQ-017 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-018 SHALL have port rx_overflow, output, 1 bit: sticky flag meaning at least one received byte was dropped.

Function
REQ-019 SHALL send bytes most-significant first: size 1 sends wd[7:0]; size 2 sends wd[15:8], then wd[7:0]; size 4 sends wd[31:24] down to wd[7:0].
REQ-020 SHALL keep tx_data stable while tx_valid is high and tx_ready is low, and SHALL present the next byte of the same entry in the cycle after a transfer.
REQ-021 SHALL pop a queue entry in the cycle its last byte transfers, and SHALL present the next entry's first byte in the following cycle.
REQ-022 SHALL enqueue a write and pulse uart_wdone in the cycle after uart_wenable when the queue is not full.
REQ-023 SHALL, when the queue is full, hold the request in a single pending register, enqueue it in the cycle after an entry is popped, and pulse uart_wdone in the cycle after that enqueue.
REQ-024 SHALL ignore uart_wenable while a request is pending; exec never issues one in that state.
REQ-025 SHALL push rx_data into the receive FIFO on every rx_valid strobe.
REQ-026 SHALL, when rx_valid arrives with the FIFO full and no pop in the same cycle, drop the byte and set rx_overflow; a push and a pop in the same cycle on a full FIFO SHALL NOT overflow.
REQ-027 SHALL run the read FSM through three states: IDLE, then COLLECT on uart_renable (latching size and clearing the byte counter), then DONE once the counter reaches the size, then IDLE.
REQ-028 SHALL, in COLLECT, pop one byte per cycle while the FIFO is not empty, shifting it into uart_rd from the least-significant end so that the first byte ends up most significant and the result is zero-extended.
REQ-029 SHALL, in DONE, pulse uart_rdone for exactly one cycle with uart_rd valid; uart_rd SHALL then hold until the next read completes.
REQ-030 SHALL give a read whose bytes are already buffered a latency of uart_rdone exactly N+1 cycles after uart_renable, where N is the byte count.
REQ-031 SHALL operate the read path and the write path fully concurrently.

Reset
REQ-032 SHALL, while rst is high, clear the queue, pending register, receive FIFO and counters, and set the FSM to IDLE.
REQ-033 SHALL drive all outputs to 0 during reset: tx_valid, uart_wdone, uart_rdone, rx_overflow, tx_data and uart_rd.
REQ-034 SHALL discard any in-flight transmit byte on reset mid-operation, with no further tx_valid until a new write arrives after reset.

Configuration
REQ-035 SHALL enable the write queue when the macro UART_IO_WQUEUE_EN is defined, giving the behaviour of REQ-022 and REQ-023.
REQ-036 SHALL, when UART_IO_WQUEUE_EN is undefined, hold a single entry with no queue and pulse uart_wdone in the cycle after that entry's last byte transfers; WQ_DEPTH SHALL then be ignored.

Verification
REQ-037 SHALL cover a single word write: wenable, wsz=10, wd=0xDEADBEEF, tx_ready=1 -> wdone at cycle+1 (queue on); tx bytes DE, AD, BE, EF on consecutive cycles.
REQ-038 SHALL cover back-pressure: tx_ready=0, five size-1 writes (0x01..0x05), WQ_DEPTH=4 -> four wdone pulses, the fifth delayed until tx_ready=1 pops an entry; output order 01..05.
REQ-039 SHALL cover a buffered read: rx bytes 0x12, 0x34 already received, then renable with rsz=01 -> rdone exactly 3 cycles later with uart_rd=0x00001234.
REQ-040 SHALL cover a starved read: renable with rsz=10 and an empty FIFO, then bytes AA, BB, CC, DD arriving 10 cycles apart -> rdone one cycle after the last pop, uart_rd=0xAABBCCDD.
REQ-041 SHALL cover overflow: 17 rx strobes with no read and RXQ_DEPTH=16 -> rx_overflow=1, and a subsequent 4-byte read returns the first four bytes.
REQ-042 SHALL cover reset mid-transfer: rst during the second byte of a word write -> tx_valid=0 and rx_overflow=0 the cycle after, with no residual bytes afterwards.
